// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer:
// FSM states, reconfig register map, counter word layout and profile table.
package pll_reconfig_pkg;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_MODE,
    S_WR_N,
    S_WR_M,
    S_WR_C0,
    S_WR_C1,
    S_START,
    S_POLL,
    S_LOCKWAIT
  } state_t;

  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_N      = 6'h03;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;

  // Output counter select lives in bits [22:18] of the C counter word
  localparam int         C_SEL_LSB = 18;
  localparam logic [4:0] C_SEL_C0  = 5'd0;
  localparam logic [4:0] C_SEL_C1  = 5'd1;

  // Each counter: [7:0] low, [15:8] high, [16] bypass, [17] odd
  typedef struct packed {
    logic [17:0] n;
    logic [17:0] m;
    logic [17:0] c0;
    logic [17:0] c1;
  } profile_t;

  localparam int PROFILE_TABLE_SIZE = 2;

  // Profile 0: N=3, M=49 (VCO 816.67 MHz), C0=19 -> 42.98 MHz, C1=28 -> 29.17 MHz
  // Profile 1: N=2, M=32 (VCO 800 MHz),    C0=16 -> 50.00 MHz, C1=25 -> 32.00 MHz
  localparam profile_t PROFILE_TABLE [PROFILE_TABLE_SIZE] = '{
    '{n: 18'h2_0201, m: 18'h2_1918, c0: 18'h2_0A09, c1: 18'h0_0E0E},
    '{n: 18'h0_0101, m: 18'h0_1010, c0: 18'h0_0808, c1: 18'h2_0D0C}
  };

  function automatic logic [31:0] counter_word(input logic [17:0] cnt,
                                               input logic [4:0]  sel);
    logic [31:0] w;
    w = '0;
    w[17:0] = cnt;
    w[C_SEL_LSB +: 5] = sel;
    return w;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_rom.sv
// Combinational profile lookup; any index outside the populated range
// returns the power-up profile 0.
module pll_profile_rom
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_PROFILES = 2,
  parameter int PW           = 1
) (
  input  logic [PW-1:0] idx,
  output profile_t      rec
);

  logic [PROFILE_TABLE_SIZE-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < PROFILE_TABLE_SIZE; gi++) begin : g_hit
      assign hit[gi] = (int'(idx) == gi) && (gi < NUM_PROFILES);
    end
  endgenerate

  always_comb begin
    rec = PROFILE_TABLE[0];
    for (int i = 0; i < PROFILE_TABLE_SIZE; i++) begin
      if (hit[i]) rec = PROFILE_TABLE[i];
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Polling-mode sequencer for the PLL reconfig management port: writes a preset
// M/N/C0/C1 profile, starts reconfiguration, waits for filtered lock.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_PROFILES = 2,
  parameter int PW           = 1,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          req,
  input  logic [PW-1:0] profile,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [PW-1:0] cur_profile,
  input  logic          pll_locked,
  output logic          domain_rst,
  output logic [5:0]    mgmt_address,
  output logic          mgmt_write,
  output logic          mgmt_read,
  output logic [31:0]   mgmt_writedata,
  input  logic [31:0]   mgmt_readdata,
  input  logic          mgmt_waitrequest
);

  localparam int            STW         = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [STW-1:0] STABLE_LAST = STW'(LOCK_STABLE - 1);
  localparam logic [19:0]    TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);

  state_t          state_reg;
  logic [STW-1:0]  stable_cnt_reg;
  logic [19:0]     timeout_cnt_reg;
  logic [PW-1:0]   profile_reg;
  logic            lock_meta_reg;
  logic            lock_sync_reg;

  profile_t        prof;
  logic [5:0]      wr_addr;
  logic [31:0]     wr_data;
  state_t          wr_next;
  logic            unused_rdata;

  // Only the status bit of the readback is meaningful
  assign unused_rdata = ^mgmt_readdata[31:1];

  pll_profile_rom #(
    .NUM_PROFILES (NUM_PROFILES),
    .PW           (PW)
  ) u_rom (
    .idx (profile_reg),
    .rec (prof)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta_reg <= 1'b0;
      lock_sync_reg <= 1'b0;
    end else begin
      lock_meta_reg <= pll_locked;
      lock_sync_reg <= lock_meta_reg;
    end
  end

  always_comb begin
    wr_addr = ADDR_MODE;
    wr_data = 32'd1;
    wr_next = S_WR_N;
    case (state_reg)
      S_WR_N: begin
        wr_addr = ADDR_N;
        wr_data = counter_word(prof.n, 5'd0);
        wr_next = S_WR_M;
      end
      S_WR_M: begin
        wr_addr = ADDR_M;
        wr_data = counter_word(prof.m, 5'd0);
        wr_next = S_WR_C0;
      end
      S_WR_C0: begin
        wr_addr = ADDR_C;
        wr_data = counter_word(prof.c0, C_SEL_C0);
        wr_next = S_WR_C1;
      end
      S_WR_C1: begin
        wr_addr = ADDR_C;
        wr_data = counter_word(prof.c1, C_SEL_C1);
        wr_next = S_START;
      end
      S_START: begin
        wr_addr = ADDR_START;
        wr_data = 32'd0;
        wr_next = S_POLL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg       <= S_INIT;
      busy            <= 1'b1;
      done            <= 1'b0;
      error           <= 1'b0;
      cur_profile     <= '0;
      domain_rst      <= 1'b1;
      mgmt_write      <= 1'b0;
      mgmt_read       <= 1'b0;
      mgmt_address    <= '0;
      mgmt_writedata  <= '0;
      stable_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      profile_reg     <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_INIT: begin
          if (lock_sync_reg) begin
            if (stable_cnt_reg == STABLE_LAST) begin
              state_reg      <= S_IDLE;
              busy           <= 1'b0;
              domain_rst     <= 1'b0;
              stable_cnt_reg <= '0;
            end else begin
              stable_cnt_reg <= stable_cnt_reg + 1'b1;
            end
          end else begin
            stable_cnt_reg <= '0;
          end
        end

        S_IDLE: begin
          // After a timeout the PLL is known unlocked; stay here so a retry
          // can be accepted instead of falling back into INIT.
          if (!lock_sync_reg && !error) begin
            state_reg      <= S_INIT;
            busy           <= 1'b1;
            domain_rst     <= 1'b1;
            stable_cnt_reg <= '0;
          end else if (req) begin
            profile_reg <= (int'(profile) < NUM_PROFILES) ? profile : '0;
            error       <= 1'b0;
            busy        <= 1'b1;
            domain_rst  <= 1'b1;
            state_reg   <= S_MODE;
          end
        end

        S_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_C1, S_START: begin
          if (!mgmt_write) begin
            mgmt_write     <= 1'b1;
            mgmt_address   <= wr_addr;
            mgmt_writedata <= wr_data;
          end else if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            state_reg  <= wr_next;
          end
        end

        S_POLL: begin
          if (!mgmt_read) begin
            mgmt_read    <= 1'b1;
            mgmt_address <= ADDR_STATUS;
          end else if (!mgmt_waitrequest) begin
            // Not-done readback leaves one idle cycle before the reissue
            mgmt_read <= 1'b0;
            if (mgmt_readdata[0]) begin
              state_reg       <= S_LOCKWAIT;
              stable_cnt_reg  <= '0;
              timeout_cnt_reg <= '0;
            end
          end
        end

        S_LOCKWAIT: begin
          timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          stable_cnt_reg  <= lock_sync_reg ? stable_cnt_reg + 1'b1 : '0;
          if (lock_sync_reg && stable_cnt_reg == STABLE_LAST) begin
            state_reg      <= S_IDLE;
            done           <= 1'b1;
            cur_profile    <= profile_reg;
            domain_rst     <= 1'b0;
            busy           <= 1'b0;
            stable_cnt_reg <= '0;
          end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
            state_reg <= S_IDLE;
            error     <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: state_reg <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a stalling Avalon-MM responder
// that logs every completed transfer.
module tb_pll_reconfig_ctrl;

  localparam int LS = 16;
  localparam int LT = 100;

  logic        refclk;
  logic        rst;
  logic        req;
  logic [0:0]  profile;
  logic        busy;
  logic        done;
  logic        error;
  logic [0:0]  cur_profile;
  logic        pll_locked;
  logic        domain_rst;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;

  int checks = 0;
  int failures = 0;

  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [5:0]  ra_q[$];
  int done_cnt, rd_ready_cnt, poll_idx, stall_seen, stall_viol;
  int stall_cfg, stall_cnt, ready_after;
  bit          stalled_prev;
  logic [5:0]  held_addr;
  logic [31:0] held_data;
  logic        held_wr;

  logic [5:0]  exp_addr [6] = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h05, 6'h02};
  logic [31:0] exp_p0   [6] = '{32'h1, 32'h0002_0201, 32'h0002_1918, 32'h0002_0A09, 32'h0004_0E0E, 32'h0};
  logic [31:0] exp_p1   [6] = '{32'h1, 32'h0000_0101, 32'h0000_1010, 32'h0000_0808, 32'h0006_0D0C, 32'h0};

  pll_reconfig_ctrl #(
    .NUM_PROFILES (2),
    .PW           (1),
    .LOCK_STABLE  (LS),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .refclk           (refclk),
    .rst              (rst),
    .req              (req),
    .profile          (profile),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .cur_profile      (cur_profile),
    .pll_locked       (pll_locked),
    .domain_rst       (domain_rst),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_read        (mgmt_read),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // Responder/monitor: decides waitrequest for the coming edge and logs the
  // transfers that will complete on it.
  initial begin
    mgmt_waitrequest = 1'b0;
    mgmt_readdata    = 32'hFFFF_FFFE;
    stall_cnt = 0;
    stalled_prev = 1'b0;
    forever begin
      @(negedge refclk);
      if (done) done_cnt++;
      if (mgmt_write || mgmt_read) begin
        if (stalled_prev && (mgmt_address !== held_addr || mgmt_writedata !== held_data ||
                             mgmt_write !== held_wr))
          stall_viol++;
        if (stall_cnt < stall_cfg) begin
          mgmt_waitrequest = 1'b1;
          stall_cnt++;
          stall_seen++;
        end else begin
          mgmt_waitrequest = 1'b0;
          if (mgmt_write) begin
            wa_q.push_back(mgmt_address);
            wd_q.push_back(mgmt_writedata);
          end else begin
            ra_q.push_back(mgmt_address);
            if (poll_idx >= ready_after) begin
              mgmt_readdata = 32'hFFFF_FFFF;
              rd_ready_cnt++;
            end else begin
              mgmt_readdata = 32'hFFFF_FFFE;
            end
            poll_idx++;
          end
        end
        stalled_prev = mgmt_waitrequest;
        held_addr = mgmt_address;
        held_data = mgmt_writedata;
        held_wr   = mgmt_write;
      end else begin
        if (stalled_prev && !rst) stall_viol++;
        stall_cnt = 0;
        mgmt_waitrequest = 1'b0;
        stalled_prev = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();
    done_cnt = 0;
    rd_ready_cnt = 0;
    poll_idx = 0;
    stall_seen = 0;
    stall_viol = 0;
  endtask

  task automatic pulse_req(input logic [0:0] p);
    @(negedge refclk);
    req = 1'b1;
    profile = p;
    @(negedge refclk);
    req = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge refclk);
    end
  endtask

  // Returns just after the negedge preceding the edge that enters LOCKWAIT
  task automatic wait_lockwait(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge refclk);
      #1;
      if (rd_ready_cnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; profile = 1'b0; pll_locked = 1'b0;
    repeat (4) @(negedge refclk);
    checks++;
    if ({busy, done, error, cur_profile, domain_rst} !== 5'b10001) begin
      failures++;
      $display("FAIL reset_status got=%b exp=10001", {busy, done, error, cur_profile, domain_rst});
    end
    checks++;
    if ({mgmt_write, mgmt_read, mgmt_address, mgmt_writedata} !== 40'd0) begin
      failures++;
      $display("FAIL reset_mgmt got=%h exp=0", {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata});
    end
    clear_log();
    rst = 1'b0;
    pll_locked = 1'b1;
    repeat (LS + 1) @(negedge refclk);
    checks++;
    if ({busy, domain_rst} !== 2'b11) begin
      failures++;
      $display("FAIL init_early got=%b exp=11", {busy, domain_rst});
    end
    @(negedge refclk);
    checks++;
    if ({busy, domain_rst, cur_profile} !== 3'b000) begin
      failures++;
      $display("FAIL init_release got=%b exp=000", {busy, domain_rst, cur_profile});
    end
    checks++;
    if (wa_q.size() + ra_q.size() != 0) begin
      failures++;
      $display("FAIL init_traffic got=%0d exp=0", wa_q.size() + ra_q.size());
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_profile1();
    bit ok;
    stall_cfg = 0; ready_after = 0;
    clear_log();
    pulse_req(1'b1);
    wait_idle(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL p1_complete got=busy exp=idle");
    end
    checks++;
    if (wa_q.size() != 6) begin
      failures++;
      $display("FAIL p1_write_count got=%0d exp=6", wa_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wa_q[i] !== exp_addr[i] || wd_q[i] !== exp_p1[i]) begin
          failures++;
          $display("FAIL p1_write%0d got=%h:%h exp=%h:%h", i, wa_q[i], wd_q[i], exp_addr[i], exp_p1[i]);
        end
      end
    end
    checks++;
    if (ra_q.size() != 1 || ra_q[0] !== 6'h01) begin
      failures++;
      $display("FAIL p1_reads got=%0d exp=1 of addr 01", ra_q.size());
    end
    checks++;
    if (done_cnt != 1 || cur_profile !== 1'b1 || error !== 1'b0 || domain_rst !== 1'b0) begin
      failures++;
      $display("FAIL p1_status got=done%0d cur%b err%b drst%b exp=done1 cur1 err0 drst0",
               done_cnt, cur_profile, error, domain_rst);
    end
    $display("test_profile1 done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_stall_poll();
    bit ok;
    stall_cfg = 3; ready_after = 2;
    clear_log();
    pulse_req(1'b0);
    wait_idle(600, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_complete got=busy exp=idle");
    end
    checks++;
    if (stall_viol != 0) begin
      failures++;
      $display("FAIL stall_stable got=%0d exp=0 violations", stall_viol);
    end
    checks++;
    if (stall_seen != 27) begin
      failures++;
      $display("FAIL stall_cycles got=%0d exp=27", stall_seen);
    end
    checks++;
    if (ra_q.size() != 3 || ra_q[0] !== 6'h01 || ra_q[1] !== 6'h01 || ra_q[2] !== 6'h01) begin
      failures++;
      $display("FAIL stall_reads got=%0d exp=3 of addr 01", ra_q.size());
    end
    checks++;
    if (wa_q.size() != 6) begin
      failures++;
      $display("FAIL stall_write_count got=%0d exp=6", wa_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wa_q[i] !== exp_addr[i] || wd_q[i] !== exp_p0[i]) begin
          failures++;
          $display("FAIL stall_write%0d got=%h:%h exp=%h:%h", i, wa_q[i], wd_q[i], exp_addr[i], exp_p0[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || cur_profile !== 1'b0) begin
      failures++;
      $display("FAIL stall_status got=done%0d cur%b exp=done1 cur0", done_cnt, cur_profile);
    end
    stall_cfg = 0; ready_after = 0;
    $display("test_stall_poll done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_timeout();
    bit ok;
    stall_cfg = 0; ready_after = 0;
    clear_log();
    pulse_req(1'b1);
    pll_locked = 1'b0;
    wait_lockwait(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL to_reach_lockwait got=no exp=yes");
    end
    for (int k = 0; k <= LT; k++) begin
      @(negedge refclk);
      if (k == LT - 1) begin
        checks++;
        if ({error, busy} !== 2'b01) begin
          failures++;
          $display("FAIL to_early got=err%b busy%b exp=err0 busy1", error, busy);
        end
      end
      if (k == LT) begin
        checks++;
        if ({error, busy, domain_rst} !== 3'b101) begin
          failures++;
          $display("FAIL to_error got=err%b busy%b drst%b exp=err1 busy0 drst1", error, busy, domain_rst);
        end
      end
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL to_no_done got=%0d exp=0", done_cnt);
    end
    clear_log();
    pulse_req(1'b0);
    checks++;
    if ({error, busy} !== 2'b01) begin
      failures++;
      $display("FAIL retry_accept got=err%b busy%b exp=err0 busy1", error, busy);
    end
    pll_locked = 1'b1;
    wait_idle(200, ok);
    checks++;
    if (!ok || wa_q.size() != 6 || wa_q[0] !== 6'h00 || wd_q[1] !== exp_p0[1]) begin
      failures++;
      $display("FAIL retry_writes got=%0d writes exp=6 from MODE", wa_q.size());
    end
    checks++;
    if (done_cnt != 1 || cur_profile !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL retry_status got=done%0d cur%b err%b exp=done1 cur0 err0", done_cnt, cur_profile, error);
    end
    $display("test_timeout done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_lock_glitch();
    bit ok;
    stall_cfg = 0; ready_after = 0;
    clear_log();
    pulse_req(1'b1);
    repeat (3) @(negedge refclk);
    pulse_req(1'b0);
    wait_lockwait(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL glitch_reach_lockwait got=no exp=yes");
    end
    for (int k = 0; k <= 27; k++) begin
      @(negedge refclk);
      if (k == 8) pll_locked = 1'b0;
      if (k == 9) pll_locked = 1'b1;
      if (k == 16 || k == 26) begin
        checks++;
        if (done !== 1'b0 || done_cnt != 0) begin
          failures++;
          $display("FAIL glitch_early_done_at%0d got=%b exp=0", k, done);
        end
      end
      if (k == 27) begin
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL glitch_done got=%b exp=1", done);
        end
      end
    end
    wait_idle(20, ok);
    checks++;
    if (!ok || cur_profile !== 1'b1) begin
      failures++;
      $display("FAIL glitch_cur_profile got=%b exp=1", cur_profile);
    end
    checks++;
    if (wa_q.size() != 6) begin
      failures++;
      $display("FAIL busy_req_write_count got=%0d exp=6", wa_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wa_q[i] !== exp_addr[i] || wd_q[i] !== exp_p1[i]) begin
          failures++;
          $display("FAIL busy_req_write%0d got=%h:%h exp=%h:%h", i, wa_q[i], wd_q[i], exp_addr[i], exp_p1[i]);
        end
      end
    end
    $display("test_lock_glitch done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_rst_midseq();
    bit ok;
    bit hit;
    stall_cfg = 50; ready_after = 0;
    clear_log();
    pulse_req(1'b0);
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge refclk);
      if (mgmt_write && mgmt_address == 6'h04) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rst_reach_wr_m got=no exp=yes");
    end
    rst = 1'b1;
    @(negedge refclk);
    checks++;
    if ({mgmt_write, busy, domain_rst, error, cur_profile} !== 5'b01100) begin
      failures++;
      $display("FAIL rst_mid got=%b exp=01100", {mgmt_write, busy, domain_rst, error, cur_profile});
    end
    rst = 1'b0;
    stall_cfg = 0;
    clear_log();
    wait_idle(60, ok);
    checks++;
    if (!ok || domain_rst !== 1'b0) begin
      failures++;
      $display("FAIL rst_relock got=busy%b drst%b exp=busy0 drst0", busy, domain_rst);
    end
    checks++;
    if (wa_q.size() != 0) begin
      failures++;
      $display("FAIL rst_no_recovery got=%0d writes exp=0", wa_q.size());
    end
    $display("test_rst_midseq done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    stall_cfg = 0;
    ready_after = 0;
    clear_log();
    test_reset();
    test_profile1();
    test_stall_poll();
    test_timeout();
    test_lock_glitch();
    test_rst_midseq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
